// File: rtl/mem_responder.sv
// Far-end responder for the hello/ack memory interface: word RAM plus one
// memory-mapped interrupt-request register, answering after WAIT_CYC wait states.
module mem_responder #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 8,
   parameter int unsigned DEPTH    = 128,
   parameter int unsigned WAIT_CYC = 2,
   parameter int unsigned INT_ADDR = 'hFF
) (
   input  logic              mem_clk_i,
   input  logic              mem_rst_n_i,
   input  logic              mem_hello_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic [DATA_W-1:0] mem_data_o,
   output logic              mem_ack_o,
   output logic              mem_int_o
);

   localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

   state_t            r_state;
   logic [3:0]        r_cnt;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic              r_ack;
   logic [DATA_W-1:0] r_data;
   logic              r_int;
   logic [DATA_W-1:0] r_mem [DEPTH];

   state_t            w_state_nxt;
   logic [3:0]        w_cnt_nxt;
   logic              w_ack_nxt;
   logic [DATA_W-1:0] w_data_nxt;
   logic              w_int_nxt;
   logic              w_ram_we;
   logic              w_latch;
   logic              w_in_ram;
   logic              w_is_int;
   logic [IDX_W-1:0]  w_idx;
   logic [DATA_W-1:0] w_rd_word;

   assign w_in_ram  = (32'(r_addr) < DEPTH);
   assign w_is_int  = (32'(r_addr) == INT_ADDR);
   assign w_idx     = r_addr[IDX_W-1:0];
   assign w_rd_word = r_mem[w_idx];

   assign mem_data_o = r_data;
   assign mem_ack_o  = r_ack;
   assign mem_int_o  = r_int;

   // Every request passes through S_WAIT (even with WAIT_CYC=0) so that ack
   // rises exactly 1+WAIT_CYC edges after the capture edge.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_ack_nxt   = r_ack;
      w_data_nxt  = r_data;
      w_int_nxt   = r_int;
      w_ram_we    = 1'b0;
      w_latch     = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ack_nxt = 1'b0;
            if (mem_hello_i) begin
               w_latch     = 1'b1;
               w_cnt_nxt   = 4'(WAIT_CYC);
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!mem_hello_i) begin
               w_cnt_nxt   = '0;
               w_state_nxt = S_IDLE;
            end else if (r_cnt == 4'd0) begin
               w_state_nxt = S_ACK;
               w_ack_nxt   = 1'b1;
               if (r_we) begin
                  w_ram_we = w_in_ram;
                  if (w_is_int) w_int_nxt = r_wdata[0];
               end else if (w_in_ram) begin
                  w_data_nxt = w_rd_word;
               end else if (w_is_int) begin
                  w_data_nxt = DATA_W'(r_int);
               end else begin
                  w_data_nxt = '0;
               end
            end else begin
               w_cnt_nxt = r_cnt - 4'd1;
            end
         end
         S_ACK: begin
            if (!mem_hello_i) begin
               w_ack_nxt   = 1'b0;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_ack_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge mem_clk_i or negedge mem_rst_n_i) begin
      if (!mem_rst_n_i) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_ack   <= 1'b0;
         r_data  <= '0;
         r_int   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_ack   <= w_ack_nxt;
         r_data  <= w_data_nxt;
         r_int   <= w_int_nxt;
         if (w_latch) begin
            r_we    <= mem_we_i;
            r_addr  <= mem_addr_i;
            r_wdata <= mem_data_i;
         end
      end
   end

   // RAM contents survive reset; w_ram_we is only ever high outside reset.
   always_ff @(posedge mem_clk_i) begin
      if (w_ram_we) r_mem[w_idx] <= r_wdata;
   end

endmodule
